mem_arbiter: RTL

- Sequential arbiter sharing one single-port RAM between the instruction-fetch requester and the data (load/store) requester of the pipelined datapath.
- Sits between the datapath/cache side and the RAM model.
- Fixed data priority with a starvation guard for instruction fetch.
- Latches the granted request and holds it stable on the RAM bus until the RAM completes, then returns a one-cycle hit to the winner.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/mem_arb_stats.sv | 33 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// +---------------------------------------------------------------------------+
// | cpu_types_pkg : types shared by the datapath memory-side blocks            |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

  // Width of the consecutive-data-grant counter; covers STARVE_MAX up to 15.
  parameter int STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IACC = 2'd1,
    ARB_DACC = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_stats.sv
// +---------------------------------------------------------------------------+
// | mem_arb_stats : grant and instruction-stall event counters for the arbiter |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_arb_stats (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        igrant,
  input  logic        dgrant,
  input  logic        istall,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] istall_cnt
);

  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrant_cnt <= '0;
      dgrant_cnt <= '0;
      istall_cnt <= '0;
    end else begin
      if (igrant) igrant_cnt <= igrant_cnt + 32'd1;
      if (dgrant) dgrant_cnt <= dgrant_cnt + 32'd1;
      if (istall) istall_cnt <= istall_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +---------------------------------------------------------------------------+
// | mem_arbiter : shares one single-port RAM between instruction fetch and    |
// |               data access; data priority with an i-fetch starvation guard |
// | Options     : MEM_ARB_STATS_EN adds grant/stall counter outputs           |
// | Revision    : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic [ADDR_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       igrant_cnt,
  output logic [31:0]       dgrant_cnt,
  output logic [31:0]       istall_cnt
`endif
);

  localparam logic [STARVE_W-1:0] STREAK_MAX = STARVE_W'(STARVE_MAX);

  arb_state_t            state;
  logic [STARVE_W-1:0]   dstreak;
  logic                  dreq;
  logic                  starved;
  logic                  igrant;
  logic                  dgrant;

  assign dreq    = dREN | dWEN;
  assign starved = iREN && (dstreak == STREAK_MAX);
  assign igrant  = (state == ARB_IDLE) && iREN && (starved || !dreq);
  assign dgrant  = (state == ARB_IDLE) && dreq && !starved;

  assign iwait = iREN & ~((state == ARB_IACC) & ram_ready);
  assign dwait = dreq & ~((state == ARB_DACC) & ram_ready);
  assign iload = ramload;
  assign dload = ramload;
  assign busy  = (state != ARB_IDLE);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= ARB_IDLE;
      dstreak  <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (igrant) begin
            state   <= ARB_IACC;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            ramaddr <= iaddr;
            dstreak <= '0;
          end else if (dgrant) begin
            state    <= ARB_DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            // A simultaneous read+write request is serviced as a write.
            ramWEN   <= dWEN;
            ramREN   <= dREN & ~dWEN;
            if (!iREN)                     dstreak <= '0;
            else if (dstreak != STREAK_MAX) dstreak <= dstreak + 1'b1;
          end
        end
        ARB_IACC, ARB_DACC: begin
          // Return to IDLE for one bubble so a still-held request is not re-served.
          if (ram_ready) begin
            state  <= ARB_IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        default: begin
          state  <= ARB_IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .CLK        (CLK),
    .nRST       (nRST),
    .igrant     (igrant),
    .dgrant     (dgrant),
    .istall     (iwait),
    .igrant_cnt (igrant_cnt),
    .dgrant_cnt (dgrant_cnt),
    .istall_cnt (istall_cnt)
  );
`endif

endmodule

`default_nettype wire
